// File: rtl/data_memory_block_if.sv
// rtl/data_memory_block_if.sv - execute-to-memory stage handshake and result bundle
interface data_memory_block_if;
  logic        valid_ex;
  logic        mem_en_ex;
  logic        mem_rw_ex;
  logic        mem_mux_sel_dm;
  logic [15:0] ans_ex;
  logic [15:0] dm_data;
  logic [15:0] ans_dm;
  logic        valid_dm;
  logic        busy_dm;
  logic        err_dm;

  modport master (
    output valid_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, ans_ex, dm_data,
    input  ans_dm, valid_dm, busy_dm, err_dm
  );

  modport slave (
    input  valid_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, ans_ex, dm_data,
    output ans_dm, valid_dm, busy_dm, err_dm
  );
endinterface

// File: rtl/data_memory_block.sv
// rtl/data_memory_block.sv - memory stage: load/store data memory with registered result
// Optional post-reset memory clear sequence under macro DM_RESET_CLEAR_EN.
module data_memory_block #(
  parameter int DM_AW = 8
) (
  input logic               clk,
  input logic               reset,
  data_memory_block_if.slave dm
);
  localparam int DEPTH = 1 << DM_AW;

  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      ans_q, ans_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy;
  logic             accept;
  logic             in_range;
  logic             is_load;
  logic             is_store;
  logic [DM_AW-1:0] addr;
  logic [15:0]      rd_data;
  logic             mem_we;
  logic [DM_AW-1:0] mem_waddr;
  logic [15:0]      mem_wdata;

  assign addr     = dm.ans_ex[DM_AW-1:0];
  assign in_range = (dm.ans_ex >> DM_AW) == 16'h0000;
  assign accept   = dm.valid_ex & ~busy & ~reset;
  assign is_load  = dm.mem_en_ex & ~dm.mem_rw_ex;
  assign is_store = dm.mem_en_ex & dm.mem_rw_ex;
  assign rd_data  = mem_q[addr];

`ifdef DM_RESET_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_e;

  state_e           state_q, state_d;
  logic [DM_AW-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Sweep every address once, then hand the memory to the pipeline.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == CLEAR);
  end
`else
  assign busy = 1'b0;
`endif

  // Single write port shared by pipeline stores and the clear sweep.
  always_comb begin
    mem_we    = accept & is_store & in_range;
    mem_waddr = addr;
    mem_wdata = dm.dm_data;
`ifdef DM_RESET_CLEAR_EN
    if (state_q == CLEAR && !reset) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = 16'h0000;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    ans_d   = ans_q;
    err_d   = err_q;
    valid_d = accept;
    if (accept) begin
      if (is_load && dm.mem_mux_sel_dm) ans_d = in_range ? rd_data : 16'h0000;
      else                              ans_d = dm.ans_ex;
      if (dm.mem_en_ex && !in_range)    err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q   <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ans_q   <= ans_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign dm.ans_dm   = ans_q;
  assign dm.valid_dm = valid_q;
  assign dm.busy_dm  = busy;
  assign dm.err_dm   = err_q;
endmodule

// File: tb/tb_data_memory_block.sv
// tb/tb_data_memory_block.sv - directed self-checking bench for data_memory_block
`timescale 1ns/1ps
module tb_data_memory_block;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  data_memory_block_if dm_if ();

  data_memory_block #(.DM_AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dm    (dm_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic en, input logic rw, input logic sel,
                       input logic [15:0] a, input logic [15:0] d);
    dm_if.valid_ex       = v;
    dm_if.mem_en_ex      = en;
    dm_if.mem_rw_ex      = rw;
    dm_if.mem_mux_sel_dm = sel;
    dm_if.ans_ex         = a;
    dm_if.dm_data        = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (dm_if.busy_dm !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (dm_if.busy_dm !== 1'b0) begin
      errors++;
      $display("FAIL wait_ready busy_dm=%b after %0d cycles, required 0", dm_if.busy_dm, n);
    end
  endtask

  task automatic test_reset();
    logic exp_busy;
`ifdef DM_RESET_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    reset = 1'b1;
    idle();
    step();
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h0000) begin
      errors++; $display("FAIL reset_ans ans_dm=%h required 0000", dm_if.ans_dm);
    end
    checks++;
    if (dm_if.valid_dm !== 1'b0) begin
      errors++; $display("FAIL reset_valid valid_dm=%b required 0", dm_if.valid_dm);
    end
    checks++;
    if (dm_if.err_dm !== 1'b0) begin
      errors++; $display("FAIL reset_err err_dm=%b required 0", dm_if.err_dm);
    end
    checks++;
    if (dm_if.busy_dm !== exp_busy) begin
      errors++; $display("FAIL reset_busy busy_dm=%b required %b", dm_if.busy_dm, exp_busy);
    end
    reset = 1'b0;
    wait_ready();
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h0010 || dm_if.valid_dm !== 1'b1) begin
      errors++; $display("FAIL store_fwd ans_dm=%h valid=%b required 0010/1", dm_if.ans_dm, dm_if.valid_dm);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'hBEEF || dm_if.valid_dm !== 1'b1) begin
      errors++; $display("FAIL store_load ans_dm=%h valid=%b required BEEF/1", dm_if.ans_dm, dm_if.valid_dm);
    end
    checks++;
    if (dm_if.err_dm !== 1'b0) begin
      errors++; $display("FAIL store_load_err err_dm=%b required 0", dm_if.err_dm);
    end
    idle();
  endtask

  task automatic test_alu_pass();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'hFFFF);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h1234 || dm_if.valid_dm !== 1'b1) begin
      errors++; $display("FAIL alu_pass ans_dm=%h valid=%b required 1234/1", dm_if.ans_dm, dm_if.valid_dm);
    end
    idle();
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h1234 || dm_if.valid_dm !== 1'b0) begin
      errors++; $display("FAIL alu_hold ans_dm=%h valid=%b required 1234/0", dm_if.ans_dm, dm_if.valid_dm);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h5555);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h0020) begin
      errors++; $display("FAIL load_nosel ans_dm=%h required 0020", dm_if.ans_dm);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h5555) begin
      errors++; $display("FAIL load_sel ans_dm=%h required 5555", dm_if.ans_dm);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] da [4] = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04};
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 16'(16'h0030 + i);
      drive(1'b1, 1'b1, 1'b1, 1'b1, a, da[i]);
      step();
      checks++;
      if (dm_if.ans_dm !== a || dm_if.valid_dm !== 1'b1) begin
        errors++; $display("FAIL b2b_store%0d ans_dm=%h valid=%b required %h/1", i, dm_if.ans_dm, dm_if.valid_dm, a);
      end
    end
    for (int i = 3; i >= 0; i--) begin
      a = 16'(16'h0030 + i);
      drive(1'b1, 1'b1, 1'b0, 1'b1, a, 16'h0000);
      step();
      checks++;
      if (dm_if.ans_dm !== da[i] || dm_if.valid_dm !== 1'b1) begin
        errors++; $display("FAIL b2b_load%0d ans_dm=%h valid=%b required %h/1", i, dm_if.ans_dm, dm_if.valid_dm, da[i]);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0031, 16'h5A5A);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0031, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h5A5A) begin
      errors++; $display("FAIL b2b_overwrite ans_dm=%h required 5A5A", dm_if.ans_dm);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h7777);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'hDEAD);
    step();
    checks++;
    if (dm_if.err_dm !== 1'b0 || dm_if.valid_dm !== 1'b0) begin
      errors++; $display("FAIL oor_not_valid err=%b valid=%b required 0/0", dm_if.err_dm, dm_if.valid_dm);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'hDEAD);
    step();
    checks++;
    if (dm_if.err_dm !== 1'b1 || dm_if.ans_dm !== 16'h0100) begin
      errors++; $display("FAIL oor_store err=%b ans_dm=%h required 1/0100", dm_if.err_dm, dm_if.ans_dm);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h0000 || dm_if.err_dm !== 1'b1) begin
      errors++; $display("FAIL oor_load ans_dm=%h err=%b required 0000/1", dm_if.ans_dm, dm_if.err_dm);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h7777) begin
      errors++; $display("FAIL oor_no_alias ans_dm=%h required 7777", dm_if.ans_dm);
    end
    idle();
    repeat (3) step();
    checks++;
    if (dm_if.err_dm !== 1'b1) begin
      errors++; $display("FAIL oor_sticky err_dm=%b required 1", dm_if.err_dm);
    end
  endtask

  task automatic test_reset_priority();
    logic [15:0] exp_prior;
`ifdef DM_RESET_CLEAR_EN
    exp_prior = 16'h0000;
`else
    exp_prior = 16'hAAAA;
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 16'hAAAA);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h1111);
    reset = 1'b1;
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h0000 || dm_if.valid_dm !== 1'b0 || dm_if.err_dm !== 1'b0) begin
      errors++; $display("FAIL rst_prio_out ans=%h valid=%b err=%b required 0000/0/0", dm_if.ans_dm, dm_if.valid_dm, dm_if.err_dm);
    end
    reset = 1'b0;
    idle();
    wait_ready();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== exp_prior) begin
      errors++; $display("FAIL rst_prio_mem ans_dm=%h required %h", dm_if.ans_dm, exp_prior);
    end
    idle();
  endtask

`ifdef DM_RESET_CLEAR_EN
  task automatic test_clear();
    int n;
    int bad;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h3331);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h3331) begin
      errors++; $display("FAIL clr_prestore ans_dm=%h required 3331", dm_if.ans_dm);
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    bad = 0;
    while (dm_if.busy_dm === 1'b1 && n < 1000) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h4444);
      step();
      n++;
      if (dm_if.valid_dm !== 1'b0) bad++;
    end
    idle();
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL clr_len busy cycles=%0d required 256", n);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL clr_drop valid_dm seen high %0d times required 0", bad);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h0000) begin
      errors++; $display("FAIL clr_ff ans_dm=%h required 0000", dm_if.ans_dm);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step();
    checks++;
    if (dm_if.ans_dm !== 16'h0000) begin
      errors++; $display("FAIL clr_dropped_store ans_dm=%h required 0000", dm_if.ans_dm);
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (100) step();
    checks++;
    if (dm_if.busy_dm !== 1'b1) begin
      errors++; $display("FAIL clr_mid busy_dm=%b required 1", dm_if.busy_dm);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    while (dm_if.busy_dm === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL clr_restart busy cycles=%0d required 256", n);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_store_load();
    test_alu_pass();
    test_back_to_back();
    test_out_of_range();
    test_reset_priority();
`ifdef DM_RESET_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_block.md
DATA_MEMORY_BLOCK -- requirements
Module: data_memory_block

Interface
REQ-001 Parameter: DM_AW, default 8, memory address width; depth = 2^DM_AW words of 16 bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: valid_ex  input  1  execute-stage result valid this cycle.
REQ-005 Port: mem_en_ex  input  1  operation accesses data memory.
REQ-006 Port: mem_rw_ex  input  1  1 = store, 0 = load; ignored when mem_en_ex = 0.
REQ-007 Port: mem_mux_sel_dm  input  1  1 = forward load data, 0 = forward ans_ex.
REQ-008 Port: ans_ex  input  16  ALU result; also the memory address.
REQ-009 Port: dm_data  input  16  store data.
REQ-010 Port: ans_dm  output  16  registered result to write-back stage.
REQ-011 Port: valid_dm  output  1  ans_dm carries a new accepted result.
REQ-012 Port: busy_dm  output  1  block not accepting operations.
REQ-013 Port: err_dm  output  1  sticky out-of-range access flag.

Function
REQ-014 Accept = valid_ex & ~busy_dm & ~reset; all stage state updates only on accept, except valid_dm.
REQ-015 Latency one cycle: accepted op at edge N drives ans_dm/valid_dm after edge N.
REQ-016 valid_dm <= accept every cycle; ans_dm holds its value when no accept.
REQ-017 Address = ans_ex[DM_AW-1:0]; in-range iff ans_ex[15:DM_AW] == 0.
REQ-018 Accepted store, in range: mem[addr] <= dm_data at same edge; ans_dm <= ans_ex.
REQ-019 Accepted load with mem_mux_sel_dm = 1: ans_dm <= mem[addr] (in range) or 16'h0000 (out of range).
REQ-020 Accepted op with mem_mux_sel_dm = 0 and not a load-forward: ans_dm <= ans_ex unchanged.
REQ-021 Out-of-range accepted access with mem_en_ex = 1: store suppressed, err_dm <= 1, held until reset.
REQ-022 Store at edge N followed by load of same address accepted at edge N+1 SHALL return the stored data.
REQ-023 valid_ex asserted while busy_dm = 1: operation dropped, no memory write, valid_dm = 0.
REQ-024 Control FSM states: CLEAR, RUN; busy_dm = 1 exactly in CLEAR.

Reset
REQ-025 Reset SHALL set ans_dm = 16'h0000, valid_dm = 0, err_dm = 0, and the FSM per REQ-027/REQ-028.
REQ-026 Reset has priority: a store presented at a reset edge is not written; in-flight result is discarded.

Configuration
REQ-027 Macro DM_RESET_CLEAR_EN defined: reset enters CLEAR, counter = 0; each cycle mem[counter] <= 0 and counter increments; after writing address 2^DM_AW-1 go to RUN (busy_dm high exactly 2^DM_AW cycles); reset during CLEAR restarts at address 0.
REQ-028 Macro DM_RESET_CLEAR_EN undefined: reset enters RUN directly, busy_dm is constant 0, memory contents survive reset and are undefined at power-up.

Verification
REQ-029 Store ans_ex=16'h0010, dm_data=16'hBEEF, then load 16'h0010 with mem_mux_sel_dm=1 next cycle -> ans_dm=16'hBEEF with valid_dm=1 one cycle after load.
REQ-030 ALU op ans_ex=16'h1234, mem_en_ex=0, mem_mux_sel_dm=0 -> ans_dm=16'h1234 one cycle later; then valid_ex=0 -> ans_dm holds 16'h1234, valid_dm=0.
REQ-031 Store to ans_ex=16'h0100 (DM_AW=8) -> err_dm=1, no write; load 16'h0100 -> ans_dm=16'h0000; err_dm stays 1 until reset.
REQ-032 Store ans_ex=16'h0005 dm_data=16'h1111 presented with reset=1 -> after reset, load 16'h0005 returns prior content (not 16'h1111); ans_dm=0, valid_dm=0 on the reset cycle.
REQ-033 DM_RESET_CLEAR_EN: pre-store 16'h3331 at 16'h00FF, reset -> busy_dm high 256 cycles, ops offered meanwhile dropped; afterwards load 16'h00FF -> 16'h0000; reset at cycle 100 of CLEAR restarts full 256-cycle clear.
